arch_state_probe: RTL and testbench
===================================

ARCH_STATE_PROBE -- requirements
Module: arch_state_probe

Interface
REQ-001 Parameter XLEN, 32, architectural data width.
REQ-002 Parameter PREG_W, 7, physical register tag width.
REQ-003 Parameter CNT_W, 32, width of every event counter.
REQ-004 Parameter TIMEOUT, 1000, consecutive no-commit cycles that raise hang; legal range 1 to 2**CNT_W-1.
REQ-005 Parameter WATCH_MASK, 32'h0000_0C80, bit i set = architectural register xi is dumped; bit 0 is ignored.
REQ-006 clk  in  1  sole clock; all state updates on rising edge.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 commit_valid  in  1  ROB retired an instruction this cycle.
REQ-009 mispredict  in  1  branch mispredict flush this cycle.
REQ-010 dump_req  in  1  one-cycle request to start a register dump.
REQ-011 hang_clear  in  1  clears sticky hang flag.
REQ-012 map_rd_addr  out  5  architectural index to rename-map read port (combinational read).
REQ-013 map_rd_data  in  PREG_W  physical tag for map_rd_addr, same cycle.
REQ-014 prf_rd_addr  out  PREG_W  PRF read address; data returns one cycle later.
REQ-015 prf_rd_data  in  XLEN  PRF data for previous cycle's prf_rd_addr.
REQ-016 dump_valid / dump_ready  out / in  1 / 1  valid-ready handshake of dump stream.
REQ-017 dump_areg, dump_preg, dump_data, dump_last  out  5, PREG_W, XLEN, 1  dump record fields.
REQ-018 dump_busy  out  1  high from accepted dump_req until final record handshake.
REQ-019 commit_count, mispredict_count  out  CNT_W  saturating event counters.
REQ-020 hang  out  1  sticky: TIMEOUT consecutive cycles without commit_valid.

Function
REQ-021 FSM states IDLE, LOOKUP, READ, HOLD; IDLE --accepted dump_req--> LOOKUP with index 1.
REQ-022 dump_req SHALL be accepted only in IDLE and only if WATCH_MASK[31:1] is non-zero; otherwise ignored.
REQ-023 LOOKUP: map_rd_addr = index; if WATCH_MASK[index] set, register map_rd_data as dump_preg, drive prf_rd_addr = map_rd_data, go READ; else index+1 and stay (one cycle per skipped register).
REQ-024 READ: capture prf_rd_data into dump_data, go HOLD; dump_valid asserts first cycle of HOLD (3-cycle latency per watched register, excluding skips).
REQ-025 HOLD: dump_areg, dump_preg, dump_data, dump_last stable while dump_valid && !dump_ready; on handshake, go IDLE if dump_last else LOOKUP at index+1.
REQ-026 dump_last SHALL be 1 exactly when no WATCH_MASK bit above dump_areg is set; index never wraps past 31.
REQ-027 Each record samples map/PRF at its own LOOKUP/READ cycles; mispredict mid-dump does not abort or restart the dump.
REQ-028 commit_count/mispredict_count increment by 1 per cycle their input is high; hold at all-ones.
REQ-029 Idle counter clears on commit_valid, else increments saturating; hang sets when it reaches TIMEOUT.
REQ-030 hang_clear clears hang and idle counter; if hang_clear and set condition coincide, clear wins.
REQ-031 Counters and hang operate in every FSM state, independent of dump activity.

Reset
REQ-032 reset SHALL force FSM to IDLE, index 1, dump_valid 0, dump_busy 0, dump fields 0, both counters 0, idle counter 0, hang 0, address outputs 0.
REQ-033 reset mid-dump SHALL abandon the dump with no further records emitted.

Structure
REQ-034 Package probe_pkg holds the FSM state enum and the 5-bit architectural index type.
REQ-035 One sub-module sat_counter (parameter W, inputs inc/clr, output value) SHALL implement the commit, mispredict and idle counters.

Verification
REQ-036 Default mask, map x7->40, x10->12, x11->3, PRF 40=0x11, 12=0xFFFF_FFFE, 3=0x5, ready=1 -> three records in order (7,40,0x11),(10,12,-2),(11,3,5), last only on x11.
REQ-037 Same dump, dump_ready low 4 cycles on record x10 -> record held stable, no loss or duplicate, busy until x11 accepted.
REQ-038 TIMEOUT=8, no commits -> hang rises after 8 cycles of no commit; commit then does not clear it; hang_clear clears it same cycle set would recur.
REQ-039 CNT_W=4, commit_valid high 20 cycles -> commit_count saturates at 15.
REQ-040 dump_req while busy, and reset asserted during HOLD -> second request ignored; after reset all outputs 0, no record emitted.

Source files
------------

// File: rtl/probe_pkg.sv
// probe_pkg: shared FSM state, architectural index type and mask helper.
package probe_pkg;
  typedef enum logic [1:0] {IDLE, LOOKUP, READ, HOLD} state_t;
  typedef logic [4:0] areg_t;
  function automatic logic none_above(input logic [31:0] mask, input areg_t idx);
    return ((mask >> idx) >> 1) == 32'd0;
  endfunction
endpackage

// File: rtl/sat_counter.sv
// sat_counter: clearable up-counter that holds at all-ones.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] value
);
  logic [W-1:0] value_q, value_d;
  always_comb value_d = clr ? '0 : (inc && !(&value_q)) ? value_q + W'(1) : value_q;
  always_ff @(posedge clk) value_q <= reset ? '0 : value_d;
  assign value = value_q;
endmodule

// File: rtl/arch_state_probe.sv
// arch_state_probe: architectural register dump, commit/mispredict counters and hang watchdog.
module arch_state_probe
  import probe_pkg::*;
#(
  parameter int          XLEN       = 32,
  parameter int          PREG_W     = 7,
  parameter int          CNT_W      = 32,
  parameter int          TIMEOUT    = 1000,
  parameter logic [31:0] WATCH_MASK = 32'h0000_0C80
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              commit_valid,
  input  logic              mispredict,
  input  logic              dump_req,
  input  logic              hang_clear,
  output logic [4:0]        map_rd_addr,
  input  logic [PREG_W-1:0] map_rd_data,
  output logic [PREG_W-1:0] prf_rd_addr,
  input  logic [XLEN-1:0]   prf_rd_data,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [4:0]        dump_areg,
  output logic [PREG_W-1:0] dump_preg,
  output logic [XLEN-1:0]   dump_data,
  output logic              dump_last,
  output logic              dump_busy,
  output logic [CNT_W-1:0]  commit_count,
  output logic [CNT_W-1:0]  mispredict_count,
  output logic              hang
);
  localparam logic [31:0] MASK = WATCH_MASK & 32'hFFFF_FFFE;
  localparam logic [CNT_W-1:0] TO_M1 = CNT_W'(TIMEOUT - 1);
  state_t state_q, state_d;
  areg_t idx_q, idx_d, dump_areg_q, dump_areg_d;
  logic [PREG_W-1:0] dump_preg_q, dump_preg_d;
  logic [XLEN-1:0] dump_data_q, dump_data_d;
  logic dump_valid_q, dump_valid_d, dump_last_q, dump_last_d, hang_q, hang_d;
  logic [CNT_W-1:0] idle_cnt;
  logic hit;
  assign hit = state_q == LOOKUP && MASK[idx_q];
  assign map_rd_addr = state_q == LOOKUP ? idx_q : '0;
  assign prf_rd_addr = hit ? map_rd_data : '0;
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    dump_areg_d = dump_areg_q;
    dump_preg_d = dump_preg_q;
    dump_data_d = dump_data_q;
    dump_valid_d = dump_valid_q;
    dump_last_d = dump_last_q;
    case (state_q)
      IDLE: begin
        state_d = (dump_req && |MASK) ? LOOKUP : IDLE;
        idx_d = 5'd1;
      end
      LOOKUP: begin
        state_d = hit ? READ : LOOKUP;
        idx_d = hit ? idx_q : idx_q + 5'd1;
        dump_areg_d = hit ? idx_q : dump_areg_q;
        dump_preg_d = hit ? map_rd_data : dump_preg_q;
        dump_last_d = hit ? none_above(MASK, idx_q) : dump_last_q;
      end
      READ: begin
        state_d = HOLD;
        dump_data_d = prf_rd_data;
        dump_valid_d = 1'b1;
      end
      HOLD: begin
        state_d = !dump_ready ? HOLD : dump_last_q ? IDLE : LOOKUP;
        idx_d = !dump_ready ? idx_q : dump_last_q ? 5'd1 : idx_q + 5'd1;
        dump_valid_d = !dump_ready;
      end
    endcase
  end
  // clear wins over a coincident set; counting continues regardless of dump activity
  always_comb hang_d = hang_clear ? 1'b0 : hang_q | (!commit_valid && idle_cnt >= TO_M1);
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q <= 5'd1;
      dump_areg_q <= '0;
      dump_preg_q <= '0;
      dump_data_q <= '0;
      dump_valid_q <= 1'b0;
      dump_last_q <= 1'b0;
      hang_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      dump_areg_q <= dump_areg_d;
      dump_preg_q <= dump_preg_d;
      dump_data_q <= dump_data_d;
      dump_valid_q <= dump_valid_d;
      dump_last_q <= dump_last_d;
      hang_q <= hang_d;
    end
  end
  assign dump_valid = dump_valid_q;
  assign dump_areg = dump_areg_q;
  assign dump_preg = dump_preg_q;
  assign dump_data = dump_data_q;
  assign dump_last = dump_last_q;
  assign dump_busy = state_q != IDLE;
  assign hang = hang_q;
  sat_counter #(.W(CNT_W)) u_commit (.clk(clk), .reset(reset), .inc(commit_valid), .clr(1'b0), .value(commit_count));
  sat_counter #(.W(CNT_W)) u_misp (.clk(clk), .reset(reset), .inc(mispredict), .clr(1'b0), .value(mispredict_count));
  sat_counter #(.W(CNT_W)) u_idle (.clk(clk), .reset(reset), .inc(1'b1), .clr(commit_valid | hang_clear), .value(idle_cnt));
endmodule

// File: tb/tb_arch_state_probe.sv
// tb_arch_state_probe: table vectors, random counter/hang model and dump sequences.
module tb_arch_state_probe;
  localparam logic [31:0] MASK = 32'h0000_0C80;
  typedef struct packed {logic [4:0] a; logic [6:0] p; logic [31:0] d; logic l;} rec_t;
  typedef struct {logic c; logic h; logic e;} vec_t;
  logic clk = 0, reset = 1, commit_valid = 0, mispredict = 0, dump_req = 0, hang_clear = 0, dump_ready = 1;
  logic [4:0] map_rd_addr, dump_areg;
  logic [6:0] map_rd_data, prf_rd_addr, dump_preg;
  logic [31:0] prf_rd_data, dump_data;
  logic dump_valid, dump_last, dump_busy, hang;
  logic [3:0] commit_count, mispredict_count;
  logic [6:0] map_m [32];
  logic [31:0] prf_m [128];
  rec_t got[$];
  int total = 0, bad = 0;
  int m_commit, m_misp, m_idle, m_hang;
  always #5 clk = ~clk;
  arch_state_probe #(.XLEN(32), .PREG_W(7), .CNT_W(4), .TIMEOUT(8), .WATCH_MASK(MASK)) dut (
    .clk(clk), .reset(reset), .commit_valid(commit_valid), .mispredict(mispredict),
    .dump_req(dump_req), .hang_clear(hang_clear), .map_rd_addr(map_rd_addr),
    .map_rd_data(map_rd_data), .prf_rd_addr(prf_rd_addr), .prf_rd_data(prf_rd_data),
    .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_areg(dump_areg),
    .dump_preg(dump_preg), .dump_data(dump_data), .dump_last(dump_last),
    .dump_busy(dump_busy), .commit_count(commit_count), .mispredict_count(mispredict_count),
    .hang(hang));
  assign map_rd_data = map_m[map_rd_addr];
  always @(posedge clk) prf_rd_data <= prf_m[prf_rd_addr];
  always @(posedge clk) if (!reset && dump_valid && dump_ready) got.push_back('{dump_areg, dump_preg, dump_data, dump_last});
  // reference: saturating event counts and a run-length of cycles without commit
  always @(posedge clk) begin
    if (reset) begin
      m_commit = 0; m_misp = 0; m_idle = 0; m_hang = 0;
    end else begin
      if (commit_valid && m_commit < 15) m_commit++;
      if (mispredict && m_misp < 15) m_misp++;
      if (hang_clear) begin
        m_idle = 0; m_hang = 0;
      end else begin
        m_idle = commit_valid ? 0 : (m_idle < 15 ? m_idle + 1 : 15);
        if (m_idle >= 8) m_hang = 1;
      end
    end
  end
  task automatic check(input string n, input logic [63:0] a, input logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask
  task automatic step();
    @(posedge clk); #1;
    check("commit_count", 64'(commit_count), 64'(m_commit));
    check("mispredict_count", 64'(mispredict_count), 64'(m_misp));
    check("hang_model", 64'(hang), 64'(m_hang));
  endtask
  task automatic check_zero(input string n);
    check({n, "_valid"}, 64'(dump_valid), 0);
    check({n, "_busy"}, 64'(dump_busy), 0);
    check({n, "_fields"}, 64'({dump_areg, dump_preg, dump_data, dump_last}), 0);
    check({n, "_counts"}, 64'({commit_count, mispredict_count, hang}), 0);
    check({n, "_addr"}, 64'({map_rd_addr, prf_rd_addr}), 0);
  endtask
  task automatic run_dump(input int st_areg, input int st_n, input bit dup);
    rec_t exp_q[$];
    rec_t snap;
    int stalls = 0, top = 0;
    bit snap_ok = 0;
    for (int i = 1; i < 32; i++) if (MASK[i]) top = i;
    for (int i = 1; i < 32; i++) if (MASK[i]) exp_q.push_back('{i[4:0], map_m[i], prf_m[map_m[i]], i == top});
    got.delete();
    dump_ready = 1; dump_req = 1;
    step();
    dump_req = 0;
    check("busy_start", 64'(dump_busy), 1);
    for (int c = 0; c < 200 && dump_busy; c++) begin
      commit_valid = 1'($urandom_range(0, 1));
      mispredict = 1'($urandom_range(0, 1));
      dump_req = dup && c == 1;
      if (dump_valid && dump_areg == 5'(st_areg) && stalls < st_n) begin
        if (snap_ok) check("hold_stable", 64'(rec_t'{dump_areg, dump_preg, dump_data, dump_last}), 64'(snap));
        snap = '{dump_areg, dump_preg, dump_data, dump_last};
        snap_ok = 1; stalls++; dump_ready = 0;
      end else dump_ready = 1;
      step();
    end
    dump_req = 0; dump_ready = 1;
    check("dump_done", 64'(dump_busy), 0);
    check("stall_cycles", 64'(stalls), 64'(st_n));
    check("rec_count", 64'(got.size()), 64'(exp_q.size()));
    for (int k = 0; k < got.size() && k < exp_q.size(); k++) check("record", 64'(got[k]), 64'(exp_q[k]));
  endtask
  initial begin
    vec_t tbl[$];
    for (int i = 0; i < 32; i++) map_m[i] = 7'(i + 64);
    for (int i = 0; i < 128; i++) prf_m[i] = $urandom;
    map_m[7] = 40; map_m[10] = 12; map_m[11] = 3;
    prf_m[40] = 32'h11; prf_m[12] = 32'hFFFF_FFFE; prf_m[3] = 32'h5;
    repeat (7) tbl.push_back('{1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 1'b1});
    tbl.push_back('{1'b1, 1'b0, 1'b1});
    repeat (7) tbl.push_back('{1'b0, 1'b0, 1'b1});
    tbl.push_back('{1'b0, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 1'b0});
    step(); step();
    check_zero("reset");
    reset = 0;
    foreach (tbl[k]) begin
      commit_valid = tbl[k].c; hang_clear = tbl[k].h;
      step();
      check("hang_vec", 64'(hang), 64'(tbl[k].e));
    end
    hang_clear = 0; commit_valid = 1;
    repeat (20) step();
    check("commit_sat", 64'(commit_count), 64'hF);
    for (int c = 0; c < 300; c++) begin
      reset = c == 150;
      commit_valid = $urandom_range(0, 3) == 0;
      mispredict = 1'($urandom_range(0, 1));
      hang_clear = $urandom_range(0, 15) == 0;
      step();
    end
    reset = 0; hang_clear = 0;
    run_dump(0, 0, 0);
    for (int i = 0; i < 32; i++) map_m[i] = 7'($urandom_range(0, 127));
    for (int i = 0; i < 128; i++) prf_m[i] = $urandom;
    run_dump(10, 4, 0);
    run_dump(0, 0, 1);
    dump_ready = 0; dump_req = 1;
    step();
    dump_req = 0;
    for (int c = 0; c < 50 && !dump_valid; c++) step();
    check("reach_hold", 64'(dump_valid), 1);
    reset = 1;
    step();
    check_zero("mid_reset");
    reset = 0; dump_ready = 1; got.delete();
    repeat (20) step();
    check("no_rec_after_reset", 64'(got.size()), 0);
    check("idle_after_reset", 64'(dump_busy), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
